// File: rtl/rand_pool_pkg.sv
// Shared types, defaults and rotation helper for the randomness rotation pool.
package rand_pool_pkg;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        READY     = 2'd1,
        EXHAUSTED = 2'd2
    } pool_state_t;

    localparam int unsigned DEF_WIDTH   = 96;
    localparam int unsigned DEF_STEP    = 8;
    localparam int unsigned DEF_TAPS    = 4;
    localparam int unsigned DEF_REFRESH = 12;

    // Widest word rotr can handle; callers zero-extend into this container.
    localparam int unsigned ROT_MAX_W = 256;

    // Right rotation of the low 'width' bits of 'word' by 'amount'.
    function automatic logic [ROT_MAX_W-1:0] rotr(input logic [ROT_MAX_W-1:0] word,
                                                  input int unsigned width,
                                                  input int unsigned amount);
        logic [ROT_MAX_W-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < ROT_MAX_W; i++) begin
            if (i < width) res[i] = word[(i + amount) % width];
        end
        return res;
    endfunction

endpackage

// File: rtl/rand_rot_tap.sv
// Combinational constant right-rotation of a WIDTH-bit word by AMOUNT bits.
module rand_rot_tap
    import rand_pool_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned AMOUNT = DEF_STEP
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (WIDTH >= ROT_MAX_W) begin : g_width_chk
        $fatal(1, "rand_rot_tap: WIDTH exceeds rotation container");
    end

    logic [ROT_MAX_W-1:0] ext;
    logic [ROT_MAX_W-1:0] rot;
    logic                 unused_hi;

    assign ext       = ROT_MAX_W'(din);
    assign rot       = rotr(ext, WIDTH, AMOUNT);
    assign dout      = rot[WIDTH-1:0];
    assign unused_hi = &{1'b0, rot[ROT_MAX_W-1:WIDTH]};

endmodule

// File: rtl/rand_rotation_pool.sv
// Fresh-randomness pool driving TAPS rotated copies, rotating STEP bits per advance.
// Build option RAND_POOL_XOR_MIX_EN: a load XORs the seed into the pool instead of replacing it.
module rand_rotation_pool
    import rand_pool_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned STEP    = DEF_STEP,
    parameter int unsigned TAPS    = DEF_TAPS,
    parameter int unsigned REFRESH = DEF_REFRESH,
    localparam int unsigned CNT_W  = $clog2(REFRESH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seed_valid,
    output logic                  seed_ready,
    input  logic [WIDTH-1:0]      seed_data,
    input  logic                  adv,
    output logic                  out_valid,
    output logic [TAPS*WIDTH-1:0] r_out,
    output logic [CNT_W-1:0]      rot_cnt
);

    if (WIDTH % STEP != 0) begin : g_chk_div
        $fatal(1, "rand_rotation_pool: WIDTH must be a multiple of STEP");
    end
    if (TAPS * STEP >= WIDTH) begin : g_chk_taps
        $fatal(1, "rand_rotation_pool: TAPS*STEP must be below WIDTH");
    end
    if (REFRESH < 1 || REFRESH > WIDTH / STEP) begin : g_chk_refresh
        $fatal(1, "rand_rotation_pool: REFRESH out of range");
    end

    pool_state_t      state;
    logic [WIDTH-1:0] pool;
    logic [WIDTH-1:0] pool_rot;
    logic [WIDTH-1:0] pool_load;

    for (genvar k = 1; k <= TAPS; k++) begin : g_tap
        rand_rot_tap #(.WIDTH(WIDTH), .AMOUNT(k * STEP)) u_tap (
            .din  (pool),
            .dout (r_out[k*WIDTH-1 -: WIDTH])
        );
    end

    rand_rot_tap #(.WIDTH(WIDTH), .AMOUNT(STEP)) u_step (
        .din  (pool),
        .dout (pool_rot)
    );

`ifdef RAND_POOL_XOR_MIX_EN
    assign pool_load = pool ^ seed_data;
`else
    assign pool_load = seed_data;
`endif

    // seed_ready is held high in both seed-accepting states, so seed_valid alone is the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            pool       <= '0;
            rot_cnt    <= '0;
            out_valid  <= 1'b0;
            seed_ready <= 1'b1;
        end else begin
            case (state)
                EMPTY, EXHAUSTED: begin
                    if (seed_valid) begin
                        pool       <= pool_load;
                        rot_cnt    <= '0;
                        state      <= READY;
                        out_valid  <= 1'b1;
                        seed_ready <= 1'b0;
                    end
                end
                READY: begin
                    if (adv) begin
                        pool <= pool_rot;
                        if (rot_cnt == CNT_W'(REFRESH - 1)) begin
                            rot_cnt    <= CNT_W'(REFRESH);
                            state      <= EXHAUSTED;
                            out_valid  <= 1'b0;
                            seed_ready <= 1'b1;
                        end else begin
                            rot_cnt <= rot_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= EMPTY;
                    out_valid  <= 1'b0;
                    seed_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_rotation_pool.sv
// Directed self-checking bench for rand_rotation_pool with hand-computed vectors.
module tb_rand_rotation_pool;
    import rand_pool_pkg::*;

    localparam int unsigned WIDTH   = 96;
    localparam int unsigned TAPS    = 4;
    localparam int unsigned CNT_W   = $clog2(12 + 1);
    localparam int unsigned CW      = TAPS * WIDTH;

    logic                  clk;
    logic                  rst_n;
    logic                  seed_valid;
    logic                  seed_ready;
    logic [WIDTH-1:0]      seed_data;
    logic                  adv;
    logic                  out_valid;
    logic [TAPS*WIDTH-1:0] r_out;
    logic [CNT_W-1:0]      rot_cnt;

    int n_vec;
    int n_miss;

    localparam logic [WIDTH-1:0] SEED1  = 96'h0B0A09080706050403020100;
    localparam logic [WIDTH-1:0] SEED2  = 96'h0B0A09080706050403020101;
    localparam logic [WIDTH-1:0] S1_R8  = 96'h000B0A090807060504030201;
    localparam logic [WIDTH-1:0] S1_R16 = 96'h01000B0A0908070605040302;
    localparam logic [WIDTH-1:0] S1_R32 = 96'h030201000B0A090807060504;
`ifdef RAND_POOL_XOR_MIX_EN
    localparam logic [WIDTH-1:0] RELOAD = 96'h000000000000000000000001;
`else
    localparam logic [WIDTH-1:0] RELOAD = SEED2;
`endif

    rand_rotation_pool dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_data  (seed_data),
        .adv        (adv),
        .out_valid  (out_valid),
        .r_out      (r_out),
        .rot_cnt    (rot_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] tap(input int k);
        return r_out[k*WIDTH-1 -: WIDTH];
    endfunction

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        rst_n      = 1'b0;
        seed_valid = 1'b0;
        seed_data  = '0;
        adv        = 1'b0;
        repeat (2) step();

        chk("rst_out_valid",  CW'(out_valid),  CW'(0));
        chk("rst_seed_ready", CW'(seed_ready), CW'(1));
        chk("rst_rot_cnt",    CW'(rot_cnt),    CW'(0));
        chk("rst_r_out",      r_out,           CW'(0));
        rst_n = 1'b1;
        step();

        // Load first seed
        seed_valid = 1'b1;
        seed_data  = SEED1;
        step();
        seed_valid = 1'b0;
        chk("load_out_valid",  CW'(out_valid),  CW'(1));
        chk("load_seed_ready", CW'(seed_ready), CW'(0));
        chk("load_rot_cnt",    CW'(rot_cnt),    CW'(0));
        chk("load_tap1",       CW'(tap(1)),     CW'(S1_R8));
        chk("load_tap2",       CW'(tap(2)),     CW'(S1_R16));
        chk("load_tap4",       CW'(tap(4)),     CW'(S1_R32));

        adv = 1'b1;
        step();
        adv = 1'b0;
        chk("adv1_pool",    CW'(dut.pool), CW'(S1_R8));
        chk("adv1_tap1",    CW'(tap(1)),   CW'(S1_R16));
        chk("adv1_rot_cnt", CW'(rot_cnt),  CW'(1));

        // Seed offered while READY is dropped
        seed_valid = 1'b1;
        seed_data  = {WIDTH{1'b1}};
        step();
        seed_valid = 1'b0;
        chk("ready_seed_ready", CW'(seed_ready), CW'(0));
        chk("ready_pool_kept",  CW'(dut.pool),   CW'(S1_R8));
        chk("ready_out_valid",  CW'(out_valid),  CW'(1));

        adv = 1'b1;
        repeat (10) step();
        chk("adv11_rot_cnt",   CW'(rot_cnt),   CW'(11));
        chk("adv11_out_valid", CW'(out_valid), CW'(1));
        step();
        chk("adv12_out_valid",  CW'(out_valid),  CW'(0));
        chk("adv12_seed_ready", CW'(seed_ready), CW'(1));
        chk("adv12_rot_cnt",    CW'(rot_cnt),    CW'(12));
        chk("adv12_pool_wrap",  CW'(dut.pool),   CW'(SEED1));
        step();
        chk("adv13_pool",    CW'(dut.pool), CW'(SEED1));
        chk("adv13_rot_cnt", CW'(rot_cnt),  CW'(12));
        chk("exh_tap1",      CW'(tap(1)),   CW'(S1_R8));

        // Reseed from EXHAUSTED with adv held: the load wins
        seed_valid = 1'b1;
        seed_data  = SEED2;
        step();
        seed_valid = 1'b0;
        adv        = 1'b0;
        chk("reseed_rot_cnt",   CW'(rot_cnt),   CW'(0));
        chk("reseed_out_valid", CW'(out_valid), CW'(1));
        chk("reseed_pool",      CW'(dut.pool),  CW'(RELOAD));

        adv = 1'b1;
        repeat (5) step();
        adv = 1'b0;
        chk("mid_rot_cnt", CW'(rot_cnt), CW'(5));

        // Asynchronous reset mid-stream, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid",  CW'(out_valid),  CW'(0));
        chk("arst_pool",       CW'(dut.pool),   CW'(0));
        chk("arst_seed_ready", CW'(seed_ready), CW'(1));
        chk("arst_rot_cnt",    CW'(rot_cnt),    CW'(0));
        step();
        rst_n = 1'b1;

        adv = 1'b1;
        step();
        adv = 1'b0;
        chk("empty_adv_rot_cnt", CW'(rot_cnt),    CW'(0));
        chk("empty_adv_pool",    CW'(dut.pool),   CW'(0));
        chk("empty_seed_ready",  CW'(seed_ready), CW'(1));

        seed_valid = 1'b1;
        seed_data  = SEED1;
        step();
        seed_valid = 1'b0;
        chk("reload_out_valid", CW'(out_valid), CW'(1));
        chk("reload_tap4",      CW'(tap(4)),    CW'(S1_R32));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rand_rotation_pool.md
Name: rand_rotation_pool

Overview:
- Sequential, parametrised successor to the fixed 96-bit randomness rotation network used by the low-randomness masked MIDORI S-box stages.
- Holds one fresh-randomness word (the "pool") in a register.
- Drives TAPS rotated copies of the pool to the masked S-box layer.
- On each advance request, rotates the pool in place by STEP bits.
- After REFRESH advances, stops advertising valid randomness and requests a new seed from the PRNG.

Parameters:
- WIDTH, 96, pool width in bits.
- STEP, 8, rotation granularity in bits; tap k is rotated right by k*STEP.
- TAPS, 4, number of rotated output taps (k = 1..TAPS).
- REFRESH, 12, advances allowed per seed before reseed is required.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seed_valid  in  1  PRNG offers a new seed.
- seed_ready  out  1  pool accepts a seed this cycle.
- seed_data  in  WIDTH  seed word.
- adv  in  1  consumer used current taps; rotate pool.
- out_valid  out  1  taps carry usable randomness.
- r_out  out  TAPS*WIDTH  tap k occupies bits [k*WIDTH-1 : (k-1)*WIDTH].
- rot_cnt  out  $clog2(REFRESH+1)  advances since last load.

Behaviour:
- One clock domain; reset is asynchronous, active-low.
- Reset values: state EMPTY, pool 0, rot_cnt 0, out_valid 0, seed_ready 1, r_out 0.
- Tap rule: tap k = {pool[k*STEP-1:0], pool[WIDTH-1:k*STEP]}, a right rotation.
  - Pure wiring from the pool register; no added latency.
- FSM states:
  - EMPTY: seed_ready=1, out_valid=0.
  - READY: seed_ready=0, out_valid=1.
  - EXHAUSTED: seed_ready=1, out_valid=0.
- Transitions:
  - EMPTY or EXHAUSTED, seed_valid & seed_ready: pool loaded, rot_cnt<=0, next state READY. out_valid rises the cycle after the handshake.
  - READY, adv: pool <= pool rotated right by STEP, rot_cnt<=rot_cnt+1.
  - READY, adv with rot_cnt==REFRESH-1: pool rotates, rot_cnt<=REFRESH, next state EXHAUSTED.
- adv outside READY is ignored: no rotation, no count.
- seed_valid in READY is ignored: no handshake, data dropped.
- In EXHAUSTED the pool keeps its value and r_out stays driven, but out_valid=0.
- Simultaneous seed handshake and adv in EMPTY/EXHAUSTED: the load wins and adv is ignored.
- rot_cnt saturates at REFRESH; it never wraps.
- Reset mid-operation returns to EMPTY with the pool cleared, regardless of any pending handshake.
- Elaboration-time checks (fatal on violation):
  - WIDTH % STEP == 0
  - TAPS*STEP < WIDTH
  - 1 <= REFRESH <= WIDTH/STEP, which prevents reusing a rotation phase within one seed.

Optional Feature:
- Macro RAND_POOL_XOR_MIX_EN.
- Defined: a load performs pool <= pool ^ seed_data. This accumulates entropy across reseeds; the first load after reset equals seed_data because the pool is 0.
- Undefined: a load performs pool <= seed_data, full replacement.
- All other behaviour is identical in both builds.

Decomposition:
- Package rand_pool_pkg holds:
  - the state enum (EMPTY, READY, EXHAUSTED);
  - default parameter constants;
  - a constant function rotr(word, amount) used by the taps and the pool update.
- One sub-module, rand_rot_tap: combinational constant right-rotation by a parameter AMOUNT. It is instantiated TAPS times via generate, plus once for the pool update with AMOUNT=STEP.

Test Plan:
- Reset then load seed 96'h0B0A09080706050403020100:
  - cycle after handshake: out_valid=1, rot_cnt=0;
  - tap1=96'h000B0A090807060504030201;
  - tap4=96'h030201000B0A090807060504.
- One adv pulse after load: pool=96'h000B0A090807060504030201, tap1=96'h01000B0A0908070605040302, rot_cnt=1.
- 12 consecutive adv: on the 12th, out_valid falls, seed_ready=1, rot_cnt=12, and the pool equals the original seed (full wrap). A 13th adv leaves pool and rot_cnt unchanged.
- In READY, assert seed_valid with 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF: seed_ready=0 and the pool is unchanged. In EXHAUSTED with seed_valid and adv together: load occurs, rot_cnt=0, no rotation.
- Assert rst_n=0 mid-stream at rot_cnt=5: immediately out_valid=0, pool=0, seed_ready=1; after release, state is EMPTY.
- With RAND_POOL_XOR_MIX_EN, load 96'h…0100 then after exhaustion load 96'h…0101 (same upper bytes): pool equals the XOR of the second seed with the wrapped first seed, 96'h000000000000000000000001.
